axis_pkt_fifo: RTL

//  Store-and-forward packet FIFO directly downstream of the mod3_2 stage.
//  - Accepts AXI-stream bytes and releases only complete, correctly framed packets.
//  - A correct packet is exactly packet_length beats, with tlast on the final beat.
//  - Malformed packets are dropped and counted, so downstream never sees a partial frame.

---
 rtl/axis_pkt_pkg.sv | 16 +
 rtl/sdp_ram.sv | 25 ++
 rtl/axis_pkt_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types and sizing helpers for the store-and-forward packet FIFO.
package axis_pkt_pkg;

  typedef enum logic {
    IN_RECV    = 1'b0,
    IN_DISCARD = 1'b1
  } in_state_t;

  localparam int DROP_CNT_W = 16;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram #(
  parameter int width = 9,
  parameter int depth = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-stream packet FIFO: only complete packets of exactly
// packet_length beats ending in tlast are released; malformed ones are dropped.
module axis_pkt_fifo
  import axis_pkt_pkg::*;
#(
  parameter int packet_length = 8,
  parameter int data_width    = 8,
  parameter int pkt_depth     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [data_width-1:0]       input_tdata,
  input  logic                        input_tvalid,
  output logic                        input_tready,
  input  logic                        input_tlast,
  output logic [data_width-1:0]       output_tdata,
  output logic                        output_tvalid,
  input  logic                        output_tready,
  output logic                        output_tlast,
  output logic [$clog2(pkt_depth):0]  pkt_level,
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int DEPTH = packet_length * pkt_depth;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = ptr_w(DEPTH);
  localparam int CW    = $clog2(packet_length);
  localparam int LW    = $clog2(pkt_depth) + 1;
  localparam int RW    = data_width + 1;

  // Handshake: a beat transfers on a rising edge where tvalid && tready; the
  // sender holds tdata/tlast stable while tvalid is high and tready is low.

  in_state_t             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic                  ram_pend_q, ram_pend_d;
  logic [RW-1:0]         out_q, out_d, skid_q, skid_d;
  logic [RW-1:0]         ram_rdata;
  logic [PW-1:0]         used, inflight;
  logic                  in_fire, last_beat, ram_we, commit, drop_inc;
  logic                  pop, rd_issue;

  assign used         = wr_ptr_q - rd_ptr_q;
  assign input_tready = reset_n && ((state_q == IN_DISCARD) || (used < PW'(DEPTH)));
  assign in_fire      = input_tvalid && input_tready;
  assign last_beat    = (in_cnt_q == CW'(packet_length - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    in_cnt_d    = in_cnt_q;
    ram_we      = 1'b0;
    commit      = 1'b0;
    drop_inc    = 1'b0;
    case (state_q)
      IN_RECV: begin
        if (in_fire) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          in_cnt_d = in_cnt_q + CW'(1);
          if (input_tlast && last_beat) begin
            wr_commit_d = wr_ptr_q + PW'(1);
            in_cnt_d    = '0;
            commit      = 1'b1;
          end else if (input_tlast) begin
            wr_ptr_d = wr_commit_q;
            in_cnt_d = '0;
            drop_inc = 1'b1;
          end else if (last_beat) begin
            // Too long: rewind now, swallow the rest until its tlast.
            wr_ptr_d = wr_commit_q;
            in_cnt_d = '0;
            state_d  = IN_DISCARD;
          end
        end
      end
      IN_DISCARD: begin
        if (in_fire && input_tlast) begin
          drop_inc = 1'b1;
          in_cnt_d = '0;
          state_d  = IN_RECV;
        end
      end
      default: state_d = IN_RECV;
    endcase
    drop_d = (drop_inc && (drop_q != '1)) ? drop_q + DROP_CNT_W'(1) : drop_q;
  end

  // rd_ptr frees space only when a beat leaves the output register;
  // fetch_ptr runs ahead by at most two beats (output + skid).
  assign pop      = out_vld_q && output_tready;
  assign inflight = fetch_ptr_q - rd_ptr_q;
  assign rd_issue = (fetch_ptr_q != wr_commit_q) && ((inflight - PW'(pop)) < PW'(2));

  always_comb begin
    out_vld_d   = out_vld_q;
    out_d       = out_q;
    skid_vld_d  = skid_vld_q;
    skid_d      = skid_q;
    ram_pend_d  = rd_issue;
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    fetch_ptr_d = fetch_ptr_q + PW'(rd_issue);
    level_d     = level_q + LW'(commit) - LW'(pop && out_q[RW-1]);
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = ram_pend_q;
        skid_d     = ram_rdata;
      end else if (ram_pend_q) begin
        out_vld_d = 1'b1;
        out_d     = ram_rdata;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_pend_q) begin
      skid_vld_d = 1'b1;
      skid_d     = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IN_RECV;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      in_cnt_q    <= '0;
      drop_q      <= '0;
      level_q     <= '0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      skid_vld_q  <= 1'b0;
      skid_q      <= '0;
      ram_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      in_cnt_q    <= in_cnt_d;
      drop_q      <= drop_d;
      level_q     <= level_d;
      out_vld_q   <= out_vld_d;
      out_q       <= out_d;
      skid_vld_q  <= skid_vld_d;
      skid_q      <= skid_d;
      ram_pend_q  <= ram_pend_d;
    end
  end

  sdp_ram #(
    .width(RW),
    .depth(DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({input_tlast, input_tdata}),
    .re    (rd_issue),
    .raddr (fetch_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign output_tvalid = out_vld_q;
  assign output_tdata  = out_q[data_width-1:0];
  assign output_tlast  = out_q[RW-1];
  assign pkt_level     = level_q;
  assign drop_count    = drop_q;

endmodule
